fir_sample_feeder: RTL and testbench

Input-side companion to the serial 11-tap FIR filter. It accepts bursty signed samples from upstream over a valid/ready handshake, buffers them in a small FIFO, and releases exactly one sample per 16-clock filter frame. Each sample is held stable through the cycle in which the filter latches its input. The feeder sits directly in front of the filter and shares its clock and reset, so both frame counters run in lock-step from reset release.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_sample_feeder_if.sv | 14 +
 rtl/feeder_fifo.sv | 67 ++++++
 rtl/fir_sample_feeder.sv | 105 ++++++++++
 tb/tb_fir_sample_feeder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial 11-tap FIR filter and its sample feeder.
// Holds the default sample width and frame length, the signed sample type,
// and the frame slot in which the feeder pops its next sample.
package fir_pkg;

  localparam int INPUT_WIDTH = 18;
  localparam int FRAME_LEN   = 16;

  // The counter value on whose exit edge the feeder loads o_data. The
  // filter latches o_data in the following (last) cycle of the frame.
  localparam int POP_SLOT = FRAME_LEN - 2;

  typedef logic signed [INPUT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Upstream sample handshake into the feeder (valid/ready).
// Ports: i_data (sample), i_valid (upstream has a sample), o_ready (feeder can accept).
// A transfer happens on any rising clock edge where i_valid and o_ready are both high.
interface fir_sample_feeder_if;
  import fir_pkg::*;

  sample_t i_data;
  logic    i_valid;
  logic    o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/feeder_fifo.sv
// Synchronous FIFO buffering upstream samples for the feeder.
// Latency: a pushed word is readable on rdata_o the cycle after the push edge.
// Backpressure: full_o/empty_o/level_o are registered; push when full and pop when empty are ignored.
// Ports: clk_i, rst_i (async, active-high), push_i/wdata_i, pop_i/rdata_o (head word), full_o, empty_o, level_o.
module feeder_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty; pointers wrap mod 2*DEPTH.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    level_d  = wr_ptr_d - rd_ptr_d;
  end

  // Flags are computed from next-state pointers so they come straight off flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == (AW+1)'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds the serial FIR one buffered sample per FRAME_LEN-clock frame, held stable while the filter latches it.
// Latency: a push is visible on o_data after 1 to FRAME_LEN*(o_level+1) clocks; o_sync marks the latch cycle.
// Backpressure: up.o_ready = not-full (registered); bursts up to FIFO_DEPTH are absorbed.
// Ports: i_clk, i_rst (async, active-high), up (slave: i_data/i_valid/o_ready), i_clr (clears o_underflow),
//        o_data, o_sync, o_level, o_underflow (sticky, set when a frame pops an empty FIFO).
// Build option: FEEDER_HOLD_EN -- on underflow o_data keeps its previous value instead of loading 0.
module fir_sample_feeder #(
  parameter int INPUT_WIDTH = fir_pkg::INPUT_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_LEN   = fir_pkg::FRAME_LEN
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  fir_sample_feeder_if.slave            up,
  input  logic                          i_clr,
  output logic signed [INPUT_WIDTH-1:0] o_data,
  output logic                          o_sync,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underflow
);
  import fir_pkg::*;

  localparam int CW = $clog2(FRAME_LEN);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  // Shared pop slot, tracking a locally overridden frame length.
  localparam int POP_AT = POP_SLOT + (FRAME_LEN - fir_pkg::FRAME_LEN);

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          sync_q, sync_d;
  logic                          uf_q, uf_d;
  logic signed [INPUT_WIDTH-1:0] data_q, data_d;

  logic                          pop_evt;
  logic                          fifo_push, fifo_pop;
  logic                          fifo_full, fifo_empty;
  logic [INPUT_WIDTH-1:0]        fifo_rdata;
  logic [LW-1:0]                 fifo_level;

  // Pop fires on the edge leaving the pop slot, so o_data is loaded one
  // cycle before the filter latches it and is stable through that cycle.
  assign pop_evt   = (cnt_q == CW'(POP_AT));
  assign fifo_push = up.i_valid & ~fifo_full;
  // No bypass: a word pushed on the pop edge of an empty FIFO waits a frame.
  assign fifo_pop  = pop_evt & ~fifo_empty;
  assign up.o_ready = ~fifo_full;

  feeder_fifo #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .wdata_i (up.i_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    cnt_d = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + 1'b1;
    // Registered o_sync: high for exactly the cycle the counter sits at FRAME_LEN-1.
    sync_d = (cnt_d == CW'(FRAME_LEN - 1));

    data_d = data_q;
    if (pop_evt && !fifo_empty) begin
      data_d = fifo_rdata;
    end
`ifndef FEEDER_HOLD_EN
    else if (pop_evt) begin
      data_d = '0;
    end
`endif

    // An underflow on the same edge as i_clr takes priority.
    uf_d = uf_q;
    if (pop_evt && fifo_empty) begin
      uf_d = 1'b1;
    end else if (i_clr) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
      uf_q   <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      uf_q   <= uf_d;
      data_q <= data_d;
    end
  end

  assign o_data      = data_q;
  assign o_sync      = sync_q;
  assign o_level     = fifo_level;
  assign o_underflow = uf_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed expectations at fixed cycles.
// Cycle N means N rising edges since reset release (frame counter == N mod 16).
module tb_fir_sample_feeder;

  localparam int W = 18;
  localparam int D = 8;
  localparam int F = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic signed [W-1:0] o_data;
  logic                o_sync;
  logic [3:0]          o_level;
  logic                o_uf;

  fir_sample_feeder_if up_if();

  fir_sample_feeder #(
    .INPUT_WIDTH (W),
    .FIFO_DEPTH  (D),
    .FRAME_LEN   (F)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .up          (up_if),
    .i_clr       (clr),
    .o_data      (o_data),
    .o_sync      (o_sync),
    .o_level     (o_level),
    .o_underflow (o_uf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  int                  cyc = 0;
  bit                  model_on = 1'b0;
  int                  n_push = 0;
  logic signed [W-1:0] mq[$];
  logic signed [W-1:0] m_data = '0;
  bit                  m_uf = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame model: one pop per frame from a plain queue, evaluated per edge.
  always @(posedge clk) begin
    if (model_on) begin
      automatic bit pop_edge  = ((cyc % F) == F - 2);
      automatic bit rdy       = (mq.size() < D);
      automatic bit was_empty = (mq.size() == 0);
      if (pop_edge && !was_empty) begin
        m_data = mq.pop_front();
      end
`ifndef FEEDER_HOLD_EN
      else if (pop_edge) begin
        m_data = '0;
      end
`endif
      if (pop_edge && was_empty) m_uf = 1'b1;
      else if (clr)              m_uf = 1'b0;
      if (up_if.i_valid && rdy) begin
        mq.push_back(up_if.i_data);
        n_push++;
      end
      cyc++;
      #1;
      chk("m_data",  o_data, m_data);
      chk("m_sync",  o_sync, ((cyc % F) == F - 1));
      chk("m_ready", up_if.o_ready, (mq.size() < D));
      chk("m_level", o_level, mq.size());
      chk("m_uflow", o_uf, m_uf);
    end
  end

  task automatic chk_reset_vals();
    chk("rst_data",  o_data, 0);
    chk("rst_sync",  o_sync, 0);
    chk("rst_ready", up_if.o_ready, 1);
    chk("rst_level", o_level, 0);
    chk("rst_uflow", o_uf, 0);
  endtask

  // Assert reset now (possibly mid-cycle), check outputs before any edge, release on a negedge.
  task automatic reset_now();
    model_on      = 1'b0;
    rst           = 1'b1;
    up_if.i_valid = 1'b0;
    up_if.i_data  = '0;
    clr           = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    mq.delete();
    m_data   = '0;
    m_uf     = 1'b0;
    cyc      = 0;
    n_push   = 0;
    rst      = 1'b0;
    model_on = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_now();
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send1(input logic signed [W-1:0] v);
    int start;
    bit ok;
    start = n_push;
    ok    = 1'b0;
    up_if.i_valid = 1'b1;
    up_if.i_data  = v;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (n_push != start) begin
        ok = 1'b1;
        break;
      end
    end
    up_if.i_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout at cycle %0d: sample %0d not accepted, expected acceptance", cyc, v);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    up_if.i_valid = 1'b0;
    up_if.i_data  = '0;

    // 1: idle after reset -> zero samples, sync at 15/31/47, underflow after 14
    do_reset();
    at(14); chk("t1_uf14", o_uf, 0);   chk("t1_sync14", o_sync, 0);
    at(15); chk("t1_sync15", o_sync, 1); chk("t1_uf15", o_uf, 1); chk("t1_data15", o_data, 0);
    at(16); chk("t1_sync16", o_sync, 0);
    at(31); chk("t1_sync31", o_sync, 1);
    at(47); chk("t1_sync47", o_sync, 1); chk("t1_data47", o_data, 0);

    // 2: burst of three samples at cycle 2
    do_reset();
    at(2);
    send1(18'sd5); send1(-18'sd7); send1(18'sd131071);
    at(5);  chk("t2_level5", o_level, 3);
    at(15); chk("t2_data15", o_data, 5);  chk("t2_level15", o_level, 2);
    at(31); chk("t2_data31", o_data, -7);
    at(47); chk("t2_data47", o_data, 131071); chk("t2_level47", o_level, 0);
    chk("t2_uf47", o_uf, 0);

    // 3: nine back-to-back samples from cycle 1; the ninth waits for the first pop
    do_reset();
    at(1);
    for (int i = 0; i < 8; i++) send1(W'(100 + i));
    chk("t3_ready9", up_if.o_ready, 0); chk("t3_level9", o_level, 8);
    send1(18'sd108);
    chk("t3_level16", o_level, 8); chk("t3_ready16", up_if.o_ready, 0);
    chk("t3_data16", o_data, 100);

    // 4: push on the pop edge of an empty FIFO -> underflow, sample shows a frame later
    do_reset();
    at(14);
    send1(18'sd77);
    chk("t4_uf15", o_uf, 1); chk("t4_data15", o_data, 0); chk("t4_level15", o_level, 1);
    at(31); chk("t4_data31", o_data, 77); chk("t4_level31", o_level, 0);
    at(47);
`ifdef FEEDER_HOLD_EN
    chk("t4_data47_hold", o_data, 77);
`else
    chk("t4_data47_zero", o_data, 0);
`endif

    // 5: clear with nothing pending, then clear colliding with an underflow
    at(50); pulse_clr(); chk("t5_clr51", o_uf, 0);
    at(62); pulse_clr(); chk("t5_clr63_set_wins", o_uf, 1);

    // 6: asynchronous reset mid-cycle 20 with words queued
    do_reset();
    at(2);
    send1(18'sd1); send1(18'sd2); send1(18'sd3); send1(18'sd4);
    at(20); chk("t6_level20", o_level, 3); chk("t6_data20", o_data, 1);
    #2;
    reset_now();
    at(14); chk("t6_sync14", o_sync, 0);
    at(15); chk("t6_sync15", o_sync, 1); chk("t6_level15", o_level, 0);

    repeat (2) @(negedge clk);
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
